// File: rtl/moore_pattern_tx.sv
// moore_pattern_tx
//   Moore-style serial pattern transmitter. A Start request seen in IDLE
//   captures a WIDTH-bit pattern and a repeat count. The pattern is then
//   shifted out MSB-first, one bit per clock, for Repeat+1 frames. An idle
//   gap of GAP_CYCLES clocks separates consecutive frames. All outputs are
//   decoded from registered state only.
//
//   Optional feature macro: MOORE_PATTERN_TX_PARITY_EN
//     When defined, each frame ends with an even-parity bit (the XOR of the
//     pattern bits), so a frame is WIDTH+1 bits long.
//     When undefined, a frame is WIDTH bits and no parity logic exists.
//
// Parameters
//   WIDTH       pattern length in bits (2..16)
//   GAP_CYCLES  idle cycles between frames (0..15); 0 = back-to-back
//
// Ports
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset
//   Start      transfer request, sampled only in IDLE
//   Pattern    frame bits, captured when Start is accepted
//   Repeat     extra frames; total frames = Repeat+1
//   SerialOut  serial bit, 0 when not transmitting
//   BitValid   high while SerialOut carries a frame bit
//   Busy       high while shifting or in an inter-frame gap
//   Done       one-cycle pulse after the final bit of the final frame
module moore_pattern_tx #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Pattern,
  input  logic [3:0]       Repeat,
  output logic             SerialOut,
  output logic             BitValid,
  output logic             Busy,
  output logic             Done
);

`ifdef MOORE_PATTERN_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam logic [4:0] BIT_LAST = 5'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Full on-wire frame for a pattern. With parity enabled the parity bit
  // sits in the LSB, so it leaves the shifter last.
  function automatic logic [FRAME_LEN-1:0] frame_bits(input logic [WIDTH-1:0] p);
`ifdef MOORE_PATTERN_TX_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

  logic [1:0]           state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  // Copy of the frame captured at acceptance. Repeated frames are reloaded
  // from this copy, so later changes on Pattern do not affect a transfer.
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [3:0]           frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          shift_d     = frame_bits(Pattern);
          frame_d     = frame_bits(Pattern);
          frame_cnt_d = Repeat;
          bit_cnt_d   = 5'd0;
          gap_cnt_d   = 4'd0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d   = {shift_q[FRAME_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = 5'd0;
          if (frame_cnt_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            frame_cnt_d = frame_cnt_q - 4'd1;
            shift_d     = frame_q;
            gap_cnt_d   = 4'd0;
            // With no gap the next frame's MSB follows directly.
            if (GAP_CYCLES > 0) state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        // Start is deliberately not looked at here; a new request is
        // accepted only from IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      frame_q     <= '0;
      bit_cnt_q   <= 5'd0;
      gap_cnt_q   <= 4'd0;
      frame_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Moore outputs: decoded from registered state and the shifter MSB.
  assign SerialOut = (state_q == S_SHIFT) && shift_q[FRAME_LEN-1];
  assign BitValid  = (state_q == S_SHIFT);
  assign Busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_moore_pattern_tx.sv
module tb_moore_pattern_tx;

`ifdef MOORE_PATTERN_TX_PARITY_EN
  localparam int FL = 5;
  localparam logic [15:0] F1011 = 16'b10111;
  localparam logic [15:0] F1001 = 16'b10010;
`else
  localparam int FL = 4;
  localparam logic [15:0] F1011 = 16'b1011;
  localparam logic [15:0] F1001 = 16'b1001;
`endif

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic [3:0] pat, pat2;
  logic [3:0] rep, rep2;
  logic       ser, vld, busy, done;
  logic       ser2, vld2, busy2, done2;

  int tests = 0;
  int fails = 0;

  moore_pattern_tx #(.WIDTH(4), .GAP_CYCLES(2)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Pattern(pat), .Repeat(rep),
    .SerialOut(ser), .BitValid(vld), .Busy(busy), .Done(done)
  );

  moore_pattern_tx #(.WIDTH(4), .GAP_CYCLES(0)) dut_b2b (
    .Clk(clk), .Rst(rst), .Start(start2), .Pattern(pat2), .Repeat(rep2),
    .SerialOut(ser2), .BitValid(vld2), .Busy(busy2), .Done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping "1011" Moore detector fed from the back-to-back stream.
  logic [2:0] det_q;
  logic       det_out;
  always_ff @(posedge clk) begin
    if (rst) det_q <= 3'd0;
    else begin
      case (det_q)
        3'd0: det_q <= ser2 ? 3'd1 : 3'd0;
        3'd1: det_q <= ser2 ? 3'd1 : 3'd2;
        3'd2: det_q <= ser2 ? 3'd3 : 3'd0;
        3'd3: det_q <= ser2 ? 3'd4 : 3'd2;
        default: det_q <= ser2 ? 3'd1 : 3'd2;
      endcase
    end
  end
  assign det_out = (det_q == 3'd4);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares {SerialOut, BitValid, Busy, Done} of the gapped instance.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, ser, vld, busy, done}, {28'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one frame starting at the current cycle; leaves the bench in
  // the cycle right after the frame's last bit.
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      chk_out(tag, {bits[i], 3'b110});
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; pat = 4'b1011; rep = 4'd0;
    start2 = 1'b0; pat2 = 4'b0000; rep2 = 4'd0;
    #1;

    // Reset held with Start high
    repeat (3) begin
      step();
      chk_out("reset", 4'b0000);
    end
    rst = 1'b0; start = 1'b0;
    step(); chk_out("idle_after_reset", 4'b0000);
    step(); chk_out("idle_after_reset2", 4'b0000);

    // Single frame 1011
    pat = 4'b1011; rep = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    expect_frame("single_1011", F1011, FL);
    chk_out("single_done", 4'b0001);
    step(); chk_out("single_idle", 4'b0000);

    // Single frame 1001
    pat = 4'b1001; start = 1'b1;
    step(); start = 1'b0;
    expect_frame("single_1001", F1001, FL);
    chk_out("single_1001_done", 4'b0001);
    step(); chk_out("single_1001_idle", 4'b0000);

    // Three frames with gaps; inputs changed after acceptance; Start in gap
    pat = 4'b1011; rep = 4'd2; start = 1'b1;
    step(); start = 1'b0; pat = 4'b0100; rep = 4'd9;
    expect_frame("rep_f0", F1011, FL);
    chk_out("rep_gap0a", 4'b0010);
    start = 1'b1;
    step(); start = 1'b0;
    chk_out("rep_gap0b", 4'b0010);
    step();
    expect_frame("rep_f1", F1011, FL);
    chk_out("rep_gap1a", 4'b0010); step();
    chk_out("rep_gap1b", 4'b0010); step();
    expect_frame("rep_f2", F1011, FL);
    chk_out("rep_done", 4'b0001);
    step(); chk_out("rep_idle", 4'b0000);
    step(); chk_out("rep_no_extra", 4'b0000);

    // Reset during bit 2 of frame 0
    pat = 4'b1011; rep = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk_out("mid_b0", 4'b1110); step();
    chk_out("mid_b1", 4'b0110); step();
    chk_out("mid_b2", 4'b1110);
    rst = 1'b1;
    step(); chk_out("mid_rst", 4'b0000);
    rst = 1'b0;
    step(); chk_out("mid_no_done", 4'b0000);
    step(); chk_out("mid_idle", 4'b0000);
    start = 1'b1;
    step(); start = 1'b0;
    expect_frame("mid_restart", F1011, FL);
    chk_out("mid_restart_done", 4'b0001);
    step();

    // Start held high: one transfer per Done plus one idle cycle
    pat = 4'b1001; rep = 4'd0; start = 1'b1;
    step();
    expect_frame("held_f0", F1001, FL);
    chk_out("held_done0", 4'b0001);
    step(); chk_out("held_idle", 4'b0000);
    step();
    expect_frame("held_f1", F1001, FL);
    chk_out("held_done1", 4'b0001);
    start = 1'b0;
    step(); chk_out("held_end_idle", 4'b0000);
    step(); chk_out("held_end_idle2", 4'b0000);

    // Back-to-back frames into the "1011" detector
    pat2 = 4'b1011; rep2 = 4'd1; start2 = 1'b1;
    step(); start2 = 1'b0;
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      logic [3:0] e;
      if (c <= 2 * FL) e = {F1011[FL - 1 - ((c - 1) % FL)], 3'b110};
      else             e = 4'b0001;
      chk($sformatf("b2b_out_c%0d", c), {28'd0, ser2, vld2, busy2, done2}, {28'd0, e});
      chk($sformatf("b2b_det_c%0d", c), {31'd0, det_out},
          {31'd0, (c == 5) || (c == 5 + FL)});
      step();
    end
    chk("b2b_idle", {28'd0, ser2, vld2, busy2, done2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
